// File: rtl/axis_frame_filter.sv
// Store-and-forward AXI-Stream frame filter: frames are buffered until tlast,
// bad (tuser) frames and frames that overflow the FIFO are dropped.
module axis_frame_filter #(
    parameter int DATA_WIDTH  = 32,
    parameter int KEEP_ENABLE = 1,
    parameter int KEEP_WIDTH  = 4,
    parameter int DEPTH       = 16
) (
    input  logic                  clk,
    input  logic                  rst,

    input  logic [DATA_WIDTH-1:0] s_axis_tdata,
    input  logic [KEEP_WIDTH-1:0] s_axis_tkeep,
    input  logic                  s_axis_tvalid,
    input  logic                  s_axis_tlast,
    input  logic                  s_axis_tuser,
    output logic                  s_axis_tready,

    output logic [DATA_WIDTH-1:0] m_axis_tdata,
    output logic [KEEP_WIDTH-1:0] m_axis_tkeep,
    output logic                  m_axis_tvalid,
    output logic                  m_axis_tlast,
    output logic                  m_axis_tuser,
    input  logic                  m_axis_tready,

    output logic                  status_good_frame,
    output logic                  status_bad_frame,
    output logic                  status_overflow
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;
    localparam int MW = DATA_WIDTH + KEEP_WIDTH + 1;
    localparam logic [PW-1:0] DEPTH_P = PW'(DEPTH);
    localparam logic [PW-1:0] ONE_P   = PW'(1);

    typedef enum logic {PASS, DROP} wr_state_e;

    wr_state_e       state_q, state_d;
    logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]   commit_ptr_q, commit_ptr_d;
    logic [PW-1:0]   rd_ptr_q, rd_ptr_d;

    logic                  out_valid_q, out_valid_d;
    logic [DATA_WIDTH-1:0] out_data_q, out_data_d;
    logic [KEEP_WIDTH-1:0] out_keep_q, out_keep_d;
    logic                  out_last_q, out_last_d;

    logic good_q, good_d;
    logic bad_q, bad_d;
    logic ovf_q, ovf_d;

    logic [MW-1:0] mem [DEPTH];
    logic [MW-1:0] wr_word;
    logic [MW-1:0] rd_word;
    logic          mem_we;

    logic accept;
    logic full;
    logic empty;
    logic load;

    assign s_axis_tready = ~rst;
    assign accept        = s_axis_tvalid & ~rst;
    // full is judged against the read pointer before any same-cycle read
    assign full          = (wr_ptr_q - rd_ptr_q) == DEPTH_P;
    assign empty         = commit_ptr_q == rd_ptr_q;
    assign load          = ~empty & (~out_valid_q | m_axis_tready);

    assign wr_word = {s_axis_tdata, s_axis_tkeep, s_axis_tlast};
    assign rd_word = mem[rd_ptr_q[AW-1:0]];

    // Write side: frame acceptance, commit and drop decisions
    always_comb begin
        state_d      = state_q;
        wr_ptr_d     = wr_ptr_q;
        commit_ptr_d = commit_ptr_q;
        mem_we       = 1'b0;
        good_d       = 1'b0;
        bad_d        = 1'b0;
        ovf_d        = 1'b0;
        if (accept) begin
            case (state_q)
                PASS: begin
                    if (full) begin
                        wr_ptr_d = commit_ptr_q;
                        ovf_d    = 1'b1;
                        state_d  = s_axis_tlast ? PASS : DROP;
                    end else begin
                        mem_we   = 1'b1;
                        wr_ptr_d = wr_ptr_q + ONE_P;
                        if (s_axis_tlast) begin
                            if (s_axis_tuser) begin
                                wr_ptr_d = commit_ptr_q;
                                bad_d    = 1'b1;
                            end else begin
                                commit_ptr_d = wr_ptr_q + ONE_P;
                                good_d       = 1'b1;
                            end
                        end
                    end
                end
                DROP: begin
                    if (s_axis_tlast) state_d = PASS;
                end
                default: state_d = PASS;
            endcase
        end
    end

    // Read side: single registered output stage
    always_comb begin
        rd_ptr_d    = rd_ptr_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_keep_d  = out_keep_q;
        out_last_d  = out_last_q;
        if (load) begin
            rd_ptr_d    = rd_ptr_q + ONE_P;
            out_valid_d = 1'b1;
            {out_data_d, out_keep_d, out_last_d} = rd_word;
        end else if (m_axis_tready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= PASS;
            wr_ptr_q     <= '0;
            commit_ptr_q <= '0;
            rd_ptr_q     <= '0;
            out_valid_q  <= 1'b0;
            out_data_q   <= '0;
            out_keep_q   <= '0;
            out_last_q   <= 1'b0;
            good_q       <= 1'b0;
            bad_q        <= 1'b0;
            ovf_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            wr_ptr_q     <= wr_ptr_d;
            commit_ptr_q <= commit_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            out_valid_q  <= out_valid_d;
            out_data_q   <= out_data_d;
            out_keep_q   <= out_keep_d;
            out_last_q   <= out_last_d;
            good_q       <= good_d;
            bad_q        <= bad_d;
            ovf_q        <= ovf_d;
        end
    end

    // Storage is deliberately left out of reset
    always_ff @(posedge clk) begin
        if (mem_we) mem[wr_ptr_q[AW-1:0]] <= wr_word;
    end

    generate
        if (KEEP_ENABLE != 0) begin : g_keep
            assign m_axis_tkeep = out_keep_q;
        end else begin : g_nokeep
            assign m_axis_tkeep = '1;
        end
    endgenerate

    assign m_axis_tdata      = out_data_q;
    assign m_axis_tvalid     = out_valid_q;
    assign m_axis_tlast      = out_last_q;
    assign m_axis_tuser      = 1'b0;
    assign status_good_frame = good_q;
    assign status_bad_frame  = bad_q;
    assign status_overflow   = ovf_q;

endmodule

// File: tb/tb_axis_frame_filter.sv
// Directed + randomized bench for axis_frame_filter against a queue-based
// reference model of buffered frames and the one-beat output register.
module tb_axis_frame_filter;

    localparam int DEPTH = 16;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] s_axis_tdata = '0;
    logic [3:0]  s_axis_tkeep = '0;
    logic        s_axis_tvalid = 1'b0;
    logic        s_axis_tlast = 1'b0;
    logic        s_axis_tuser = 1'b0;
    logic        s_axis_tready;
    logic [31:0] m_axis_tdata;
    logic [3:0]  m_axis_tkeep;
    logic        m_axis_tvalid;
    logic        m_axis_tlast;
    logic        m_axis_tuser;
    logic        m_axis_tready = 1'b1;
    logic        status_good_frame;
    logic        status_bad_frame;
    logic        status_overflow;

    axis_frame_filter #(.DATA_WIDTH(32), .KEEP_ENABLE(1), .KEEP_WIDTH(4), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst),
        .s_axis_tdata(s_axis_tdata), .s_axis_tkeep(s_axis_tkeep),
        .s_axis_tvalid(s_axis_tvalid), .s_axis_tlast(s_axis_tlast),
        .s_axis_tuser(s_axis_tuser), .s_axis_tready(s_axis_tready),
        .m_axis_tdata(m_axis_tdata), .m_axis_tkeep(m_axis_tkeep),
        .m_axis_tvalid(m_axis_tvalid), .m_axis_tlast(m_axis_tlast),
        .m_axis_tuser(m_axis_tuser), .m_axis_tready(m_axis_tready),
        .status_good_frame(status_good_frame), .status_bad_frame(status_bad_frame),
        .status_overflow(status_overflow)
    );

    always #5 clk = ~clk;

    typedef struct { logic [31:0] d; logic [3:0] k; logic l; } beat_t;

    // Reference model: committed frames waiting, frame in progress, output register
    beat_t       mq[$];
    beat_t       pq[$];
    logic        m_drop;
    logic        m_ov;
    beat_t       m_out;
    logic        e_good, e_bad, e_ovf;

    int total = 0;
    int bad = 0;
    int n_out = 0, o_good = 0, o_bad = 0, o_ovf = 0;
    int rdy_mode = 0;  // 0: always ready, 1: never, 2: toggle, 3: random

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_clear();
        mq.delete(); pq.delete();
        m_drop = 1'b0; m_ov = 1'b0;
        m_out = '{d: 32'h0, k: 4'h0, l: 1'b0};
        e_good = 1'b0; e_bad = 1'b0; e_ovf = 1'b0;
    endtask

    task automatic step();
        bit full;
        bit load;
        beat_t b;
        case (rdy_mode)
            0: m_axis_tready = 1'b1;
            1: m_axis_tready = 1'b0;
            2: m_axis_tready = ~m_axis_tready;
            default: m_axis_tready = 1'($urandom_range(0, 1));
        endcase
        if (m_axis_tvalid && m_axis_tready) n_out++;
        e_good = 1'b0; e_bad = 1'b0; e_ovf = 1'b0;
        if (rst) begin
            model_clear();
        end else begin
            full = (mq.size() + pq.size()) == DEPTH;
            load = (mq.size() > 0) && (!m_ov || m_axis_tready);
            if (load) begin
                m_out = mq.pop_front();
                m_ov  = 1'b1;
            end else if (m_axis_tready) begin
                m_ov = 1'b0;
            end
            if (s_axis_tvalid) begin
                if (m_drop) begin
                    if (s_axis_tlast) m_drop = 1'b0;
                end else if (full) begin
                    pq.delete();
                    e_ovf  = 1'b1;
                    m_drop = !s_axis_tlast;
                end else begin
                    b = '{d: s_axis_tdata, k: s_axis_tkeep, l: s_axis_tlast};
                    pq.push_back(b);
                    if (s_axis_tlast) begin
                        if (s_axis_tuser) begin
                            e_bad = 1'b1;
                        end else begin
                            e_good = 1'b1;
                            foreach (pq[i]) mq.push_back(pq[i]);
                        end
                        pq.delete();
                    end
                end
            end
        end
        @(posedge clk);
        #1;
        o_good += int'(status_good_frame);
        o_bad  += int'(status_bad_frame);
        o_ovf  += int'(status_overflow);
        chk("s_tready", s_axis_tready, !rst);
        chk("m_tvalid", m_axis_tvalid, m_ov);
        chk("m_tuser", m_axis_tuser, 1'b0);
        chk("good_pulse", status_good_frame, e_good);
        chk("bad_pulse", status_bad_frame, e_bad);
        chk("ovf_pulse", status_overflow, e_ovf);
        if (m_ov) begin
            chk("m_tdata", m_axis_tdata, m_out.d);
            chk("m_tkeep", m_axis_tkeep, m_out.k);
            chk("m_tlast", m_axis_tlast, m_out.l);
        end
    endtask

    task automatic idle(input int n);
        s_axis_tvalid = 1'b0;
        s_axis_tlast  = 1'b0;
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic send_frame(input int len, input bit usr, input logic [31:0] base,
                              input logic [3:0] lastkeep, input bit rnd);
        for (int i = 0; i < len; i++) begin
            if (rnd && $urandom_range(0, 3) == 0) idle(1);
            s_axis_tvalid = 1'b1;
            s_axis_tdata  = rnd ? $urandom : base + 32'(i);
            s_axis_tlast  = (i == len - 1);
            s_axis_tkeep  = (i == len - 1) ? lastkeep : 4'hf;
            s_axis_tuser  = (i == len - 1) ? usr : 1'($urandom_range(0, 1));
            step();
        end
        s_axis_tvalid = 1'b0;
        s_axis_tlast  = 1'b0;
        s_axis_tuser  = 1'b0;
    endtask

    initial begin
        int n0, g0, b0, v0;
        model_clear();

        // reset state
        rst = 1'b1;
        step();
        chk("rst_tvalid", m_axis_tvalid, 1'b0);
        chk("rst_tdata", m_axis_tdata, 32'h0);
        chk("rst_tkeep", m_axis_tkeep, 4'h0);
        rst = 1'b0;
        idle(2);

        // 4-beat good frame, latency 2 after tlast
        rdy_mode = 0;
        n0 = n_out; g0 = o_good;
        send_frame(4, 1'b0, 32'h1, 4'h3, 1'b0);
        chk("lat_n1_tvalid", m_axis_tvalid, 1'b0);
        idle(1);
        chk("lat_n2_tvalid", m_axis_tvalid, 1'b1);
        chk("lat_n2_tdata", m_axis_tdata, 32'h1);
        idle(8);
        chk("f4_beats", n_out - n0, 4);
        chk("f4_good", o_good - g0, 1);

        // bad frame then good frame
        n0 = n_out; g0 = o_good; b0 = o_bad;
        send_frame(3, 1'b1, 32'h100, 4'hf, 1'b0);
        send_frame(2, 1'b0, 32'h200, 4'h1, 1'b0);
        idle(8);
        chk("bad_beats", n_out - n0, 2);
        chk("bad_cnt", o_bad - b0, 1);
        chk("bad_good_cnt", o_good - g0, 1);

        // oversize frame with no downstream ready, then 5-beat frame
        rdy_mode = 1;
        n0 = n_out; v0 = o_ovf;
        send_frame(20, 1'b0, 32'h300, 4'hf, 1'b0);
        chk("ovf_beats", n_out - n0, 0);
        send_frame(5, 1'b0, 32'h400, 4'h7, 1'b0);
        rdy_mode = 0;
        idle(10);
        chk("ovf_after_beats", n_out - n0, 5);
        chk("ovf_cnt", o_ovf - v0, 1);

        // three back-to-back 6-beat frames, ready toggling
        rdy_mode = 2;
        n0 = n_out;
        send_frame(6, 1'b0, 32'h500, 4'hf, 1'b0);
        send_frame(6, 1'b0, 32'h600, 4'hf, 1'b0);
        send_frame(6, 1'b0, 32'h700, 4'hf, 1'b0);
        idle(40);
        chk("tog_beats", n_out - n0, 18);

        // reset mid-frame
        rdy_mode = 0;
        n0 = n_out;
        send_frame(2, 1'b0, 32'h800, 4'hf, 1'b0);
        s_axis_tvalid = 1'b1; s_axis_tdata = 32'h802; s_axis_tlast = 1'b0;
        rst = 1'b1;
        step();
        chk("mid_rst_tvalid", m_axis_tvalid, 1'b0);
        chk("mid_rst_tlast", m_axis_tlast, 1'b0);
        chk("mid_rst_tdata", m_axis_tdata, 32'h0);
        chk("mid_rst_tkeep", m_axis_tkeep, 4'h0);
        rst = 1'b0;
        s_axis_tvalid = 1'b0;
        send_frame(3, 1'b0, 32'h900, 4'hf, 1'b0);
        idle(8);
        chk("post_rst_beats", n_out - n0, 3);

        // nearly full FIFO with simultaneous read and write
        rdy_mode = 1;
        n0 = n_out; v0 = o_ovf;
        send_frame(16, 1'b0, 32'hA00, 4'hf, 1'b0);
        idle(3);
        rdy_mode = 0;
        send_frame(8, 1'b0, 32'hB00, 4'hf, 1'b0);
        send_frame(8, 1'b0, 32'hC00, 4'hf, 1'b0);
        send_frame(8, 1'b0, 32'hD00, 4'hf, 1'b0);
        idle(40);
        chk("rw_beats", n_out - n0, 40);
        chk("rw_no_ovf", o_ovf - v0, 0);

        // randomized traffic
        rdy_mode = 3;
        for (int f = 0; f < 40; f++) begin
            send_frame($urandom_range(1, 20), ($urandom_range(0, 4) == 0),
                       32'h0, 4'($urandom_range(1, 15)), 1'b1);
            if ($urandom_range(0, 2) == 0) idle($urandom_range(1, 4));
        end
        rdy_mode = 0;
        idle(3 * DEPTH);
        chk("drain_empty", m_axis_tvalid, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
